muldiv_unit: RTL

//  Iterative 32-bit multiply/divide unit downstream of the register file: consumes Read_data_1/Read_data_2
//  as src_a/src_b and holds results in architectural HI/LO registers. Write-back to the register file

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int BIT_SIZE_DFLT = 32;
    localparam int CNT_W         = $clog2(BIT_SIZE_DFLT) + 1;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Bit 0 of the opcode selects signed arithmetic, bit 1 selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// compare-subtract for divide. The 2*bit_size accumulator is {acc_hi, acc_lo}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int bit_size = BIT_SIZE_DFLT
) (
    input  logic                is_div,
    input  logic [bit_size-1:0] acc_hi,
    input  logic [bit_size-1:0] acc_lo,
    input  logic [bit_size-1:0] opnd,
    output logic [bit_size-1:0] nxt_hi,
    output logic [bit_size-1:0] nxt_lo
);

    logic [bit_size:0]   sum;
    logic [bit_size:0]   rem_sh;
    logic [bit_size-1:0] diff;
    logic                ge;

    // Multiply: add multiplicand when the low multiplier bit is set, then shift right.
    // Divide: shift the next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_sh = {acc_hi, acc_lo[bit_size-1]};
        ge     = (rem_sh >= {1'b0, opnd});
        // Only used when ge, so the true difference is below opnd and fits bit_size bits.
        diff   = rem_sh[bit_size-1:0] - opnd;
        if (is_div) begin
            nxt_hi = ge ? diff : rem_sh[bit_size-1:0];
            nxt_lo = {acc_lo[bit_size-2:0], ge};
        end else begin
            nxt_hi = sum[bit_size:1];
            nxt_lo = {sum[0], acc_lo[bit_size-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start; MTHI/MTLO writes accepted
//   S_RUN  | one accumulator iteration per clock, bit_size iterations
//   S_FIX  | apply result signs (or divide-by-zero values), load HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int bit_size = BIT_SIZE_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [bit_size-1:0] src_a,
    input  logic [bit_size-1:0] src_b,
    input  logic                hi_we,
    input  logic                lo_we,
    input  logic [bit_size-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic [bit_size-1:0] hi,
    output logic [bit_size-1:0] lo
);

    localparam int                cnt_w    = $clog2(bit_size) + 1;
    localparam logic [cnt_w-1:0]  last_cnt = cnt_w'(bit_size - 1);

    state_e                state_q, state_d;
    logic [cnt_w-1:0]      counter_q, counter_d;
    logic [bit_size-1:0]   acc_hi_q, acc_hi_d;
    logic [bit_size-1:0]   acc_lo_q, acc_lo_d;
    logic [bit_size-1:0]   opnd_q, opnd_d;
    logic [bit_size-1:0]   a_raw_q, a_raw_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dbz_q, dbz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [bit_size-1:0]   hi_q, hi_d;
    logic [bit_size-1:0]   lo_q, lo_d;

    logic [bit_size-1:0]   step_hi, step_lo;
    logic                  a_neg, b_neg;
    logic [bit_size-1:0]   a_mag, b_mag;
    logic [2*bit_size-1:0] prod;

    muldiv_step #(.bit_size(bit_size)) u_step (
        .is_div (is_div_q),
        .acc_hi (acc_hi_q),
        .acc_lo (acc_lo_q),
        .opnd   (opnd_q),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Next-state, datapath and HI/LO update for the whole unit.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // Magnitudes; 0x8000_0000 negates to itself, which reads correctly as unsigned 2^31.
        a_neg = op_is_signed(op) & src_a[bit_size-1];
        b_neg = op_is_signed(op) & src_b[bit_size-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
        prod  = {acc_hi_q, acc_lo_q};

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    is_div_d  = op_is_div(op);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = op_is_div(op) & (src_b == '0);
                    a_raw_d   = src_a;
                    acc_hi_d  = '0;
                    // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier out.
                    acc_lo_d  = op_is_div(op) ? a_mag : b_mag;
                    opnd_d    = op_is_div(op) ? b_mag : a_mag;
                    counter_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_hi_d  = step_hi;
                acc_lo_d  = step_lo;
                counter_d = counter_q + 1'b1;
                if (counter_q == last_cnt) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? -prod : prod;
                end else if (dbz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
